// File: rtl/arb_pkg.sv
// Shared arbitration definitions for bus requesters and the arbiter.
// Contents: requester FSM state encoding, encoded-grant constants and a
// helper that maps an arbiter port index to its grant code.
package arb_pkg;

    localparam int unsigned GNT_W = 4;

    // Requester FSM states; encodings are shared with the arbiter side.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Encoded grant: GNT_NONE means no port granted, GNT_BASE + k grants port k.
    localparam logic [GNT_W-1:0] GNT_NONE = 4'd0;
    localparam logic [GNT_W-1:0] GNT_BASE = 4'd1;

    // Grant code that selects the given arbiter port.
    function automatic logic [GNT_W-1:0] gnt_code(input int unsigned port);
        return GNT_BASE + GNT_W'(port);
    endfunction

endpackage

// File: rtl/bus_requester_if.sv
// Command and arbiter-bus signal bundle for bus_requester.
// Signals: cmd_valid/cmd_len/cmd_ready (command intake), REQ/GNT (arbiter
// handshake), beat_valid/beat_idx/beat_last (beat stream), done/timeout
// (burst completion and abort pulses).
// Modports: master = the requester, slave = command source plus arbiter.
interface bus_requester_if #(
    parameter int unsigned LEN_W = 4
);
    import arb_pkg::*;

    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;
    logic             REQ;
    logic [GNT_W-1:0] GNT;
    logic             beat_valid;
    logic [LEN_W-1:0] beat_idx;
    logic             beat_last;
    logic             done;
    logic             timeout;

    modport master (
        input  cmd_valid, cmd_len, GNT,
        output cmd_ready, REQ, beat_valid, beat_idx, beat_last, done, timeout
    );

    modport slave (
        output cmd_valid, cmd_len, GNT,
        input  cmd_ready, REQ, beat_valid, beat_idx, beat_last, done, timeout
    );

endinterface

// File: rtl/req_cmd_fifo.sv
// Command queue for bus_requester: DEPTH-entry first-in first-out buffer.
// Ports: clk, rst_n (async active-low), push/wdata (write), pop (read),
// rdata_c (head entry, combinational), empty_c, full_c (combinational flags).
// A push and a pop in the same cycle are both honoured, even when full.
module req_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             empty_c,
    output logic             full_c
);

    localparam int unsigned     PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata_c = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/bus_requester.sv
// Burst requester: queues burst commands and, one at a time, requests the
// shared bus from an encoded-grant arbiter, issuing one beat per granted
// cycle until the burst's last beat, then pulsing done.
// Ports: clk, rst_n (async active-low), bus (bus_requester_if.master):
//   cmd_valid/cmd_len/cmd_ready  command intake (cmd_len = beats - 1)
//   REQ/GNT                      arbiter request / encoded grant
//   beat_valid/beat_idx/beat_last beat stream (combinational from GNT)
//   done/timeout                 one-cycle completion / abort pulses
// Optional feature macro REQ_TIMEOUT_EN: abort a burst after TIMEOUT cycles
// in ARB without a beat. Without it, timeout is tied 0 and ARB waits forever.
module bus_requester
    import arb_pkg::*;
#(
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst_n,
    bus_requester_if.master bus
);

    // Reject illegal parameter sets at elaboration.
    if ((PORT_ID > 3) || (QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0) ||
        (TIMEOUT == 0) || (LEN_W == 0)) begin : g_param_check
        $error("bus_requester: illegal parameter set");
    end

    localparam logic [GNT_W-1:0] GNT_SELF = gnt_code(PORT_ID);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic             req_q;
    logic             done_q;
    logic             timeout_q;

    logic             granted_c;
    logic             beat_valid_c;
    logic             beat_last_c;
    logic             pop_c;
    logic             push_c;
    logic             wait_expire_c;
    logic             fifo_empty_c;
    logic             fifo_full_c;
    logic [LEN_W-1:0] fifo_rdata_c;

    // Grant decode and beat qualification; only our own grant code counts,
    // and only while requesting, so stale grants in IDLE/DONE are ignored.
    assign granted_c    = (bus.GNT == GNT_SELF);
    assign beat_valid_c = (state_q == ARB) && granted_c;
    assign beat_last_c  = beat_valid_c && (beat_cnt_q == len_q);

    // Queue control: the head is popped on IDLE->ARB. A command offered in
    // that same cycle is taken even if the queue looks full, since a slot
    // frees at the same edge; cmd_ready itself only reflects "not full".
    assign pop_c         = (state_q == IDLE) && !fifo_empty_c;
    assign push_c        = bus.cmd_valid && (!fifo_full_c || pop_c);
    assign bus.cmd_ready = !fifo_full_c;

    req_cmd_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (LEN_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wdata   (bus.cmd_len),
        .pop     (pop_c),
        .rdata_c (fifo_rdata_c),
        .empty_c (fifo_empty_c),
        .full_c  (fifo_full_c)
    );

`ifdef REQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt_q;

    // Cycles spent in ARB since entry or the last beat; expiry fires on the
    // TIMEOUT-th consecutive beatless cycle.
    assign wait_expire_c = (state_q == ARB) && !beat_valid_c &&
                           (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if ((state_q != ARB) || beat_valid_c) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
    end
`else
    assign wait_expire_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty_c) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (beat_last_c) begin
                    state_d = DONE;
                end else if (wait_expire_c) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst length and beat counter. The counter holds on the final beat so
    // an all-ones length never wraps; it is reloaded on the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else if (pop_c) begin
            len_q      <= fifo_rdata_c;
            beat_cnt_q <= '0;
        end else if (beat_valid_c && !beat_last_c) begin
            beat_cnt_q <= beat_cnt_q + CNT_ONE;
        end
    end

    // Registered status outputs, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            req_q     <= (state_d == ARB);
            done_q    <= (state_d == DONE);
            timeout_q <= wait_expire_c;
        end
    end

    assign bus.REQ        = req_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.beat_valid = beat_valid_c;
    assign bus.beat_idx   = beat_cnt_q;
    assign bus.beat_last  = beat_last_c;

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester (PORT_ID=2, LEN_W=4, QDEPTH=4,
// TIMEOUT=10). Accepted commands are pushed to a scoreboard queue; a
// negedge monitor pops them as bursts start and checks every beat index,
// last-beat flag and done pulse. Directed sequences check handshake timing.
module tb_bus_requester;
    import arb_pkg::*;

    localparam int unsigned LEN_W   = 4;
    localparam logic [3:0]  GNT_ME  = 4'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bus_requester_if #(.LEN_W(LEN_W)) bif ();

    bus_requester #(
        .PORT_ID (2),
        .LEN_W   (LEN_W),
        .QDEPTH  (4),
        .TIMEOUT (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];
    bit burst_active = 1'b0;
    int cur_len      = 0;
    int exp_idx      = 0;
    bit done_due     = 1'b0;
    int done_cnt     = 0;

    int gseq [6] = '{1, 3, 0, 3, 3, 3};
    int lens [6] = '{1, 2, 3, 0, 1, 2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive point just after the rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Sample point on the falling edge.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (bif.REQ === 1'b1) break;
            next();
            smp();
        end
        check(tag, 32'(bif.REQ), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            burst_active = 1'b0;
            exp_idx      = 0;
            done_due     = 1'b0;
        end else begin
            if (done_due) begin
                check("done_pulse", 32'(bif.done), 32'd1);
            end else if (bif.done) begin
                check("done_unexpected", 32'(bif.done), 32'd0);
            end
            done_due = 1'b0;
            if (bif.done) done_cnt++;
`ifndef REQ_TIMEOUT_EN
            check("timeout_tied", 32'(bif.timeout), 32'd0);
`endif
            if (bif.timeout) begin
                if (burst_active) burst_active = 1'b0;
                else if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (bif.beat_valid) begin
                check("beat_req", 32'(bif.REQ), 32'd1);
                if (!burst_active) begin
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", 32'(bif.beat_valid), 32'd0);
                    end else begin
                        cur_len      = exp_q.pop_front();
                        burst_active = 1'b1;
                        exp_idx      = 0;
                    end
                end
                if (burst_active) begin
                    check("beat_idx", 32'(bif.beat_idx), 32'(exp_idx));
                    check("beat_last", 32'(bif.beat_last), 32'(exp_idx == cur_len));
                    if (exp_idx == cur_len) begin
                        burst_active = 1'b0;
                        done_due     = 1'b1;
                    end
                    exp_idx++;
                end
            end else if (bif.beat_last) begin
                check("last_without_beat", 32'(bif.beat_last), 32'd0);
            end
            if (bif.cmd_valid && bif.cmd_ready) exp_q.push_back(int'(bif.cmd_len));
        end
    end

    initial begin
        int nb;
        int base;
        bif.cmd_valid = 1'b0;
        bif.cmd_len   = '0;
        bif.GNT       = GNT_NONE;
        rst_n         = 1'b0;

        // Reset state
        smp();
        check("rst_req", 32'(bif.REQ), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);
        check("rst_timeout", 32'(bif.timeout), 32'd0);
        check("rst_ready", 32'(bif.cmd_ready), 32'd1);
        next();
        next();
        rst_n = 1'b1;
        smp();
        check("ready_after_rst", 32'(bif.cmd_ready), 32'd1);

        // Single-beat burst
        next(); bif.cmd_valid = 1'b1; bif.cmd_len = 4'd0; smp();
        next(); bif.cmd_valid = 1'b0; smp();
        check("t1_req_idle", 32'(bif.REQ), 32'd0);
        next(); smp();
        check("t1_req_rise", 32'(bif.REQ), 32'd1);
        check("t1_no_beat", 32'(bif.beat_valid), 32'd0);
        next(); bif.GNT = GNT_ME; smp();
        check("t1_bv", 32'(bif.beat_valid), 32'd1);
        check("t1_last", 32'(bif.beat_last), 32'd1);
        check("t1_idx", 32'(bif.beat_idx), 32'd0);
        next(); bif.GNT = GNT_NONE; smp();
        check("t1_done", 32'(bif.done), 32'd1);
        check("t1_req_done", 32'(bif.REQ), 32'd0);
        next(); smp();
        check("t1_done_once", 32'(bif.done), 32'd0);
        check("t1_req_gap", 32'(bif.REQ), 32'd0);

        // Interleaved grant
        next(); bif.cmd_valid = 1'b1; bif.cmd_len = 4'd3; smp();
        next(); bif.cmd_valid = 1'b0; smp();
        wait_req("t2_req", 10);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            next(); bif.GNT = 4'(gseq[i]); smp();
            check("t2_bv", 32'(bif.beat_valid), 32'(gseq[i] == 3));
            if (gseq[i] == 3) begin
                check("t2_idx", 32'(bif.beat_idx), 32'(nb));
                check("t2_last", 32'(bif.beat_last), 32'(nb == 3));
                nb++;
            end
        end
        next(); bif.GNT = GNT_NONE; smp();
        check("t2_done", 32'(bif.done), 32'd1);

        // Queue full while grant withheld
        for (int i = 0; i < 6; i++) begin
            next(); bif.cmd_valid = 1'b1; bif.cmd_len = 4'(lens[i]); smp();
            check("t3_ready", 32'(bif.cmd_ready), 32'(i < 5));
        end
        for (int k = 0; k < 3; k++) begin
            next(); smp();
            check("t3_stall", 32'(bif.cmd_ready), 32'd0);
        end
        next(); bif.cmd_valid = 1'b0; bif.GNT = GNT_ME; base = done_cnt; smp();
        for (int i = 0; i < 200; i++) begin
            if (done_cnt - base >= 5) break;
            next(); smp();
        end
        check("t3_drained", 32'(done_cnt - base), 32'd5);
        next(); bif.GNT = GNT_NONE; smp();
        check("t3_req_idle", 32'(bif.REQ), 32'd0);
        check("t3_ready_empty", 32'(bif.cmd_ready), 32'd1);

        // Maximum length with continuous grant
        next(); bif.cmd_valid = 1'b1; bif.cmd_len = 4'hF; bif.GNT = GNT_ME; smp();
        next(); bif.cmd_valid = 1'b0; smp();
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            next(); smp();
            if (bif.beat_valid) nb++;
            if (bif.done) break;
        end
        check("t4_beats", 32'(nb), 32'd16);
        check("t4_done", 32'(bif.done), 32'd1);
        next(); bif.GNT = GNT_NONE; smp();

        // Reset mid-burst discards burst and queue
        next(); bif.cmd_valid = 1'b1; bif.cmd_len = 4'd7; smp();
        next(); bif.cmd_len = 4'd2; smp();
        next(); bif.cmd_valid = 1'b0; smp();
        wait_req("t5_req", 10);
        next(); bif.GNT = GNT_ME; smp();
        check("t5_idx0", 32'(bif.beat_idx), 32'd0);
        next(); smp();
        check("t5_idx1", 32'(bif.beat_idx), 32'd1);
        next(); bif.GNT = GNT_NONE; rst_n = 1'b0; smp();
        check("t5_req_rst", 32'(bif.REQ), 32'd0);
        check("t5_done_rst", 32'(bif.done), 32'd0);
        check("t5_ready_rst", 32'(bif.cmd_ready), 32'd1);
        next(); smp();
        next(); rst_n = 1'b1; smp();
        check("t5_ready_rel", 32'(bif.cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            next(); smp();
            check("t5_no_req", 32'(bif.REQ), 32'd0);
        end

`ifdef REQ_TIMEOUT_EN
        // Grant withheld: abort after 10 cycles in ARB, next command starts
        next(); bif.cmd_valid = 1'b1; bif.cmd_len = 4'd1; smp();
        next(); bif.cmd_len = 4'd0; smp();
        next(); bif.cmd_valid = 1'b0; smp();
        wait_req("t6_req", 10);
        for (int i = 1; i <= 10; i++) begin
            next(); smp();
            check("t6_timeout", 32'(bif.timeout), 32'(i == 10));
        end
        check("t6_req_drop", 32'(bif.REQ), 32'd0);
        next(); smp();
        check("t6_timeout_once", 32'(bif.timeout), 32'd0);
        check("t6_next_req", 32'(bif.REQ), 32'd1);
        next(); bif.GNT = GNT_ME; smp();
        check("t6_bv", 32'(bif.beat_valid), 32'd1);
        check("t6_last", 32'(bif.beat_last), 32'd1);
        next(); bif.GNT = GNT_NONE; smp();
        check("t6_done", 32'(bif.done), 32'd1);
`else
        // Grant withheld: request stays up indefinitely
        next(); bif.cmd_valid = 1'b1; bif.cmd_len = 4'd0; smp();
        next(); bif.cmd_valid = 1'b0; smp();
        wait_req("t6_req", 10);
        for (int i = 0; i < 20; i++) begin
            next(); smp();
        end
        check("t6_req_hold", 32'(bif.REQ), 32'd1);
        next(); bif.GNT = GNT_ME; smp();
        check("t6_bv", 32'(bif.beat_valid), 32'd1);
        next(); bif.GNT = GNT_NONE; smp();
        check("t6_done", 32'(bif.done), 32'd1);
`endif

        next(); smp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion before %0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/bus_requester.md
BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 SHALL have parameter PORT_ID, default 0: arbiter port index, 0..3.
REQ-002 SHALL have parameter LEN_W, default 4: width of the burst-length field.
REQ-003 SHALL have parameter QDEPTH, default 4: command queue depth, a power of 2.
REQ-004 SHALL have parameter TIMEOUT, default 255: cycles to wait for a grant before abort (used only with REQ_TIMEOUT_EN).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1 bit: a burst command is offered.
REQ-008 SHALL have port cmd_len, input, LEN_W bits: burst beats minus 1.
REQ-009 SHALL have port cmd_ready, output, 1 bit: the queue can accept a command.
REQ-010 SHALL have port REQ, output, 1 bit: request line to the arbiter.
REQ-011 SHALL have port GNT, input, 4 bits: encoded grant from the arbiter (0 = none, k+1 = port k).
REQ-012 SHALL have port beat_valid, output, 1 bit: a beat is transferred this cycle.
REQ-013 SHALL have port beat_idx, output, LEN_W bits: index of the current beat within the burst.
REQ-014 SHALL have port beat_last, output, 1 bit: the current beat is the final beat of the burst.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after a burst completes.
REQ-016 SHALL have port timeout, output, 1 bit: one-cycle pulse on a burst abort (tied 0 without REQ_TIMEOUT_EN).

Function
REQ-017 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready = queue not full.
REQ-018 SHALL store accepted commands in a QDEPTH-entry FIFO and serve them in order.
REQ-019 SHALL accept a command and pop the head in the same cycle when the queue is full; cmd_ready stays 0 that cycle.
REQ-020 SHALL implement FSM states IDLE, ARB and DONE.
REQ-021 SHALL move IDLE->ARB when the queue is non-empty, popping the head into len_r and clearing the beat counter.
REQ-022 SHALL hold REQ = 1 in ARB and REQ = 0 in IDLE and DONE; REQ is registered.
REQ-023 SHALL define granted = (GNT == PORT_ID+1), evaluated combinationally.
REQ-024 SHALL drive beat_valid = (state == ARB) && granted.
REQ-025 SHALL drive beat_idx = beat counter.
REQ-026 SHALL drive beat_last = beat_valid && (beat counter == len_r).
REQ-027 SHALL increment the beat counter on each beat_valid cycle; non-granted cycles leave it unchanged, because the arbiter may rotate grant away mid-burst.
REQ-028 SHALL move ARB->DONE on beat_last; DONE asserts done for 1 cycle and then goes to IDLE.
REQ-029 SHALL treat cmd_len = 0 as a 1-beat burst; all-ones cmd_len gives 2^LEN_W beats, with no counter overflow.
REQ-030 SHALL ignore any GNT value other than PORT_ID+1, including stale grants seen in IDLE or DONE.
REQ-031 SHALL give minimum back-to-back burst spacing of 2 cycles (DONE, IDLE), so REQ drops for at least 2 cycles between bursts.

Reset
REQ-032 SHALL, when rst_n is low, asynchronously force: state IDLE; queue empty; counters 0; REQ 0; done 0; timeout 0.
REQ-033 SHALL discard any burst in progress and all queued commands on reset, with no done pulse.
REQ-034 SHALL have cmd_ready = 1 in the first cycle after reset release.

Configuration
REQ-035 SHALL support macro REQ_TIMEOUT_EN.
REQ-036 SHALL, when REQ_TIMEOUT_EN is defined:
- run a wait counter in ARB that counts cycles without a beat and clears on each beat;
- when the counter reaches TIMEOUT, go ARB->IDLE, pulse timeout for 1 cycle, drop REQ and discard the remaining beats.
REQ-037 SHALL, when REQ_TIMEOUT_EN is undefined, omit the wait counter, tie timeout to 0, and wait in ARB indefinitely.

Structure
REQ-038 SHALL place state encodings (IDLE=2'd0, ARB=2'd1, DONE=2'd2) and the GNT encoding constants (GNT_NONE=4'd0, GNT_BASE=4'd1) in shared package arb_pkg, also used by the arbiter.
REQ-039 SHALL implement the command queue as sub-module req_cmd_fifo (parameters DEPTH, WIDTH).

Verification
REQ-040 SHALL cover single beat: cmd_len=0, PORT_ID=2, GNT=4'd3 in the cycle after REQ rises -> beat_valid=1, beat_last=1, beat_idx=0; done is 1 the next cycle; REQ=0 after that.
REQ-041 SHALL cover interleaved grant: cmd_len=3, GNT sequence 1,3,0,3,3,3 -> 4 beats, idx 0..3, only on GNT=3 cycles; beat_last on the 4th.
REQ-042 SHALL cover queue full: 5 commands offered back-to-back while GNT=0 -> cmd_ready=0 after 4 accepts (one popped into ARB, so the 5th is accepted); 6th stalls.
REQ-043 SHALL cover reset mid-burst: rst_n low after beat 1 of cmd_len=7 -> REQ=0 immediately, no done, queue empty, cmd_ready=1 after release.
REQ-044 SHALL cover timeout (REQ_TIMEOUT_EN, TIMEOUT=10): GNT held 0 -> timeout pulse 10 cycles after entry to ARB, REQ drops, next queued command starts.
REQ-045 SHALL cover max length: cmd_len=4'hF with continuous grant -> 16 beats, idx 0..15, beat_last at idx 15, then done.
